picoblaze_io_arbiter: RTL and testbench

Input-side scheduler for the PicoBlaze (kcpsm6) core. Collects events from three requesters: start button, keyboard scan-code stream and RTC read-back. Presents them to the processor one at a time through a single `interrupt` line and a registered `in_port` mux. Sits between the input front-ends and the kcpsm6 instance, replacing direct wiring of `in_port`/`interrupt`.

---
 rtl/picoblaze_io_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_picoblaze_io_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/picoblaze_io_arbiter.sv
// picoblaze_io_arbiter: input-side event scheduler for a kcpsm6 core.
// Three requesters (start button, keyboard FIFO, RTC read-back) are presented
// to the processor one at a time through `interrupt` and a registered
// `in_port` mux.
// Optional build macro: IO_ARB_TIMEOUT_EN adds an IRQ/SERVE watchdog that
// abandons an event after ACK_TIMEOUT cycles.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   inicio              start button level (rising edge = one event)
//   key_valid/key_code  keyboard code strobe and data
//   rtc_valid/rtc_data  RTC byte pending (held until rtc_ack)
//   rtc_ack             one-cycle pulse, RTC byte consumed
//   port_id/read_strobe kcpsm6 INPUT bus
//   interrupt_ack       kcpsm6 interrupt acknowledge
//   in_port             registered read data (00 src, 01 payload, 02 status)
//   interrupt           interrupt request
//   busy                high whenever an event is in flight
module picoblaze_io_arbiter #(
  parameter int unsigned KEY_FIFO_DEPTH = 4,
  parameter int unsigned ACK_TIMEOUT    = 1023,
  parameter logic [7:0]  START_CODE     = 8'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       rtc_valid,
  input  logic [7:0] rtc_data,
  output logic       rtc_ack,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  input  logic       interrupt_ack,
  output logic [7:0] in_port,
  output logic       interrupt,
  output logic       busy
);

  localparam int unsigned AW = $clog2(KEY_FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IRQ     = 2'd1;
  localparam logic [1:0] ST_SERVE   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [1:0] SRC_START = 2'b01;
  localparam logic [1:0] SRC_KEY   = 2'b10;
  localparam logic [1:0] SRC_RTC   = 2'b11;

  localparam logic RR_KEY = 1'b0;
  localparam logic RR_RTC = 1'b1;

  logic [1:0]    state, state_nxt;
  logic [1:0]    src, grant_src;
  logic [7:0]    payload, grant_payload;
  logic          inicio_q, start_pend, start_edge;
  logic          ovf, tmo, last_rr;
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic [7:0]    mem [KEY_FIFO_DEPTH];
  logic [7:0]    fifo_head;
  logic          fifo_empty, fifo_full, push, drop;
  logic          grant_start, grant_key, grant_rtc;
  logic          serve_done, timeout_hit, wdog_expired;
  logic          status_clr;
  logic [7:0]    in_port_nxt;

  assign count      = wr_ptr - rd_ptr;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == PW'(KEY_FIFO_DEPTH));
  assign fifo_head  = mem[rd_ptr[AW-1:0]];
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign push       = key_valid && (!fifo_full || grant_key);
  assign drop       = key_valid && fifo_full && !grant_key;
  assign start_edge = inicio && !inicio_q;
  assign status_clr = read_strobe && (port_id == 8'h02);

`ifdef IO_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] wdog;

  // Watchdog: restarts on every state change, counts while IRQ/SERVE wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog <= '0;
    end else if (state_nxt != state) begin
      wdog <= '0;
    end else if (state == ST_IRQ || state == ST_SERVE) begin
      wdog <= wdog + TW'(1);
    end
  end

  assign wdog_expired = (wdog == TW'(ACK_TIMEOUT - 1));
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = ^32'(ACK_TIMEOUT);
  assign wdog_expired       = 1'b0;
`endif

  // Next-state, grant selection and completion detection.
  always_comb begin
    state_nxt     = state;
    grant_start   = 1'b0;
    grant_key     = 1'b0;
    grant_rtc     = 1'b0;
    grant_src     = src;
    grant_payload = payload;
    serve_done    = 1'b0;
    timeout_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_pend) begin
          grant_start   = 1'b1;
          grant_src     = SRC_START;
          grant_payload = START_CODE;
          state_nxt     = ST_IRQ;
        end else if (!fifo_empty && (!rtc_valid || last_rr == RR_RTC)) begin
          grant_key     = 1'b1;
          grant_src     = SRC_KEY;
          grant_payload = fifo_head;
          state_nxt     = ST_IRQ;
        end else if (rtc_valid) begin
          grant_rtc     = 1'b1;
          grant_src     = SRC_RTC;
          grant_payload = rtc_data;
          state_nxt     = ST_IRQ;
        end
      end
      ST_IRQ: begin
        if (interrupt_ack) begin
          state_nxt = ST_SERVE;
        end else if (wdog_expired) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_RELEASE;
        end
      end
      ST_SERVE: begin
        if (read_strobe && port_id == 8'h01) begin
          serve_done = 1'b1;
          state_nxt  = ST_RELEASE;
        end else if (wdog_expired) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_RELEASE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read mux, sampled from the current port address every cycle.
  always_comb begin
    in_port_nxt = 8'h00;
    case (port_id)
      8'h00:   in_port_nxt = {6'b0, src};
      8'h01:   in_port_nxt = payload;
      8'h02:   in_port_nxt = {ovf, tmo, busy, 5'(count)};
      default: in_port_nxt = 8'h00;
    endcase
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= key_code;
    end
  end

  // State, request latches, status flags and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      src        <= 2'b00;
      payload    <= 8'h00;
      inicio_q   <= 1'b0;
      start_pend <= 1'b0;
      ovf        <= 1'b0;
      tmo        <= 1'b0;
      last_rr    <= RR_RTC;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      interrupt  <= 1'b0;
      busy       <= 1'b0;
      rtc_ack    <= 1'b0;
      in_port    <= 8'h00;
    end else begin
      state      <= state_nxt;
      src        <= grant_src;
      payload    <= grant_payload;
      inicio_q   <= inicio;
      // A fresh edge in the grant cycle is a new event, so set wins.
      start_pend <= start_edge || (start_pend && !grant_start);
      ovf        <= drop || (ovf && !status_clr);
      tmo        <= timeout_hit || (tmo && !status_clr);
      if (grant_key) begin
        last_rr <= RR_KEY;
      end else if (grant_rtc) begin
        last_rr <= RR_RTC;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (grant_key) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      interrupt <= (state_nxt == ST_IRQ);
      busy      <= (state_nxt != ST_IDLE);
      // An abandoned RTC event is still acknowledged so the source moves on.
      rtc_ack   <= (src == SRC_RTC) && (serve_done || timeout_hit);
      in_port   <= in_port_nxt;
    end
  end

endmodule

// File: tb/tb_picoblaze_io_arbiter.sv
// Directed bench for picoblaze_io_arbiter: reset state, single key service,
// start priority, key/RTC round-robin, FIFO overflow and full push+pop,
// watchdog (or its absence), and reset in the middle of an RTC event.
module tb_picoblaze_io_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       inicio;
  logic       key_valid;
  logic [7:0] key_code;
  logic       rtc_valid;
  logic [7:0] rtc_data;
  logic       rtc_ack;
  logic [7:0] port_id;
  logic       read_strobe;
  logic       interrupt_ack;
  logic [7:0] in_port;
  logic       interrupt;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int rtc_ack_cnt = 0;

  picoblaze_io_arbiter #(
    .KEY_FIFO_DEPTH(4),
    .ACK_TIMEOUT   (16),
    .START_CODE    (8'h02)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inicio       (inicio),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .rtc_valid    (rtc_valid),
    .rtc_data     (rtc_data),
    .rtc_ack      (rtc_ack),
    .port_id      (port_id),
    .read_strobe  (read_strobe),
    .interrupt_ack(interrupt_ack),
    .in_port      (in_port),
    .interrupt    (interrupt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rtc_ack === 1'b1) rtc_ack_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_port(input logic [7:0] p, output logic [7:0] d);
    port_id     = p;
    read_strobe = 1'b1;
    step();
    read_strobe = 1'b0;
    port_id     = 8'hFF;
    d           = in_port;
  endtask

  task automatic push_key(input logic [7:0] code);
    key_valid = 1'b1;
    key_code  = code;
    step();
    key_valid = 1'b0;
  endtask

  // Wait for the request, ack it, read src and payload, then step into IDLE.
  task automatic serve_event(input logic [1:0] es, input logic [7:0] ep, input string tag);
    logic [7:0] d;
    for (int i = 0; i < 8 && interrupt !== 1'b1; i++) step();
    chk({tag, "_irq"}, 8'(interrupt), 8'h01);
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    chk({tag, "_irq_drop"}, 8'(interrupt), 8'h00);
    read_port(8'h00, d);
    chk({tag, "_src"}, d, {6'b0, es});
    read_port(8'h01, d);
    chk({tag, "_payload"}, d, ep);
    chk({tag, "_rtc_ack"}, 8'(rtc_ack), (es == 2'b11) ? 8'h01 : 8'h00);
    step();
    chk({tag, "_idle_gap"}, {5'b0, rtc_ack, interrupt, busy}, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    int n;
    reset = 1'b1; inicio = 1'b0; key_valid = 1'b0; key_code = 8'h00;
    rtc_valid = 1'b0; rtc_data = 8'h00; port_id = 8'hFF;
    read_strobe = 1'b0; interrupt_ack = 1'b0;
    step(); step();
    chk("reset_flags", {5'b0, rtc_ack, interrupt, busy}, 8'h00);
    chk("reset_in_port", in_port, 8'h00);
    reset = 1'b0;
    step();

    // Single key: interrupt one cycle after the push lands.
    push_key(8'h57);
    chk("key_pre_irq", 8'(interrupt), 8'h00);
    step();
    chk("key_irq_latency", {6'b0, interrupt, busy}, 8'h03);
    read_port(8'h02, d);
    chk("status_in_irq", d, 8'h20);
    read_port(8'h7F, d);
    chk("unmapped_port", d, 8'h00);
    serve_event(2'b10, 8'h57, "key57");

    // Start edge and key in the same cycle: start first.
    inicio    = 1'b1;
    key_valid = 1'b1;
    key_code  = 8'h41;
    step();
    key_valid = 1'b0;
    serve_event(2'b01, 8'h02, "start");
    serve_event(2'b10, 8'h41, "key41");
    inicio = 1'b0;

    // Round-robin: key, rtc, key, rtc, key.
    push_key(8'h31);
    push_key(8'h32);
    push_key(8'h33);
    rtc_valid = 1'b1;
    rtc_data  = 8'hA0;
    serve_event(2'b10, 8'h31, "rr_key31");
    serve_event(2'b11, 8'hA0, "rr_rtcA0");
    rtc_data = 8'hA1;
    serve_event(2'b10, 8'h32, "rr_key32");
    serve_event(2'b11, 8'hA1, "rr_rtcA1");
    rtc_valid = 1'b0;
    serve_event(2'b10, 8'h33, "rr_key33");
    chk("rr_rtc_ack_count", 8'(rtc_ack_cnt), 8'd2);

    // Overflow: 61 is in service, 62..65 fill the FIFO, 66 is dropped.
    push_key(8'h61);
    push_key(8'h62);
    push_key(8'h63);
    push_key(8'h64);
    push_key(8'h65);
    push_key(8'h66);
    read_port(8'h02, d);
    chk("ovf_status", d, 8'hA4);
    read_port(8'h02, d);
    chk("ovf_cleared", d, 8'h24);
    serve_event(2'b10, 8'h61, "ovf_key61");
    // Push into the full FIFO on the same edge that pops 62.
    push_key(8'h67);
    read_port(8'h02, d);
    chk("full_push_pop", d, 8'h24);
    serve_event(2'b10, 8'h62, "ovf_key62");
    serve_event(2'b10, 8'h63, "ovf_key63");
    serve_event(2'b10, 8'h64, "ovf_key64");
    serve_event(2'b10, 8'h65, "ovf_key65");
    serve_event(2'b10, 8'h67, "ovf_key67");
    step(); step(); step();
    chk("ovf_no_sixth", 8'(interrupt), 8'h00);
    read_port(8'h02, d);
    chk("ovf_drained", d, 8'h00);

    // Watchdog on an unacknowledged interrupt.
    push_key(8'h70);
    step();
    chk("wd_irq", 8'(interrupt), 8'h01);
`ifdef IO_ARB_TIMEOUT_EN
    n = 0;
    while (interrupt === 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("wd_irq_cycles", 8'(n), 8'd16);
    read_port(8'h02, d);
    chk("wd_tmo_status", d, 8'h60);
    read_port(8'h02, d);
    chk("wd_tmo_cleared", d, 8'h00);
    chk("wd_event_lost", 8'(interrupt), 8'h00);
`else
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (interrupt === 1'b1) n++;
    end
    chk("no_wd_irq_held", 8'(n), 8'd20);
    read_port(8'h02, d);
    chk("no_wd_status", d, 8'h20);
    serve_event(2'b10, 8'h70, "no_wd_key70");
`endif

    // Reset during SERVE of an RTC event, with a key queued behind it.
    rtc_valid = 1'b1;
    rtc_data  = 8'h99;
    for (int i = 0; i < 8 && interrupt !== 1'b1; i++) step();
    chk("rst_rtc_irq", 8'(interrupt), 8'h01);
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    push_key(8'h55);
    chk("rst_in_serve", {6'b0, interrupt, busy}, 8'h01);
    port_id = 8'h01;
    reset   = 1'b1;
    step();
    chk("rst_mid_flags", {5'b0, rtc_ack, interrupt, busy}, 8'h00);
    chk("rst_mid_in_port", in_port, 8'h00);
    reset     = 1'b0;
    rtc_valid = 1'b0;
    port_id   = 8'hFF;
    step(); step();
    chk("rst_no_irq", 8'(interrupt), 8'h00);
    read_port(8'h02, d);
    chk("rst_fifo_empty", d, 8'h00);
    chk("rst_no_rtc_ack", 8'(rtc_ack_cnt), 8'd2);

    // After reset the first key/RTC tie goes to the key.
    push_key(8'h11);
    rtc_valid = 1'b1;
    rtc_data  = 8'h22;
    serve_event(2'b10, 8'h11, "tie_key11");
    serve_event(2'b11, 8'h22, "tie_rtc22");
    rtc_valid = 1'b0;
    chk("tie_rtc_ack_count", 8'(rtc_ack_cnt), 8'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
